// File: rtl/ucaspian_pkg.sv
// Shared types and constants for the ucaspian dendrite/neuron path.
// Holds the dendrite FSM state type, sizing constants and saturating add.
package ucaspian_pkg;

    localparam int NUM_NEURONS   = 256;
    localparam int NEURON_ADDR_W = 8;
    localparam int WEIGHT_W      = 8;
    localparam int CHARGE_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        ACC_RD,
        ACC_WR,
        DRN_RD,
        DRN_CHK,
        DRN_OUT,
        DONE,
        CLEAR
    } dendrite_state_t;

    // Signed accumulate of a weight into a charge, clamped instead of wrapping.
    function automatic logic [CHARGE_W-1:0] sat_add_charge(
        input logic [CHARGE_W-1:0] acc,
        input logic [WEIGHT_W-1:0] w
    );
        logic [CHARGE_W:0] sum;
        sum = {acc[CHARGE_W-1], acc}
            + {{(CHARGE_W+1-WEIGHT_W){w[WEIGHT_W-1]}}, w};
        // Two top bits disagree only when the true sum left the signed range.
        if (sum[CHARGE_W] != sum[CHARGE_W-1]) begin
            if (sum[CHARGE_W])
                return {1'b1, {(CHARGE_W-1){1'b0}}};
            else
                return {1'b0, {(CHARGE_W-1){1'b1}}};
        end
        return sum[CHARGE_W-1:0];
    endfunction

endpackage

// File: rtl/dp_ram_16x256.sv
// 256 x 16 simple dual-port RAM, one write port and one read port.
// Ports: clk, wr_en/wr_addr/wr_data write side, rd_en/rd_addr -> rd_data (1-cycle registered).
module dp_ram_16x256 (
    input  logic        clk,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        rd_en,
    input  logic [7:0]  rd_addr,
    output logic [15:0] rd_data
);

    logic [15:0] mem [256];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read data holds its value while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ucaspian_dendrite.sv
// Per-neuron charge accumulator: sums synapse weights during a step, then drains
// non-zero charges to the neuron block on next_step, clearing each entry as it goes.
// Ports: clk/reset; enable; clear_act/clear_done; next_step/step_done;
//        syn_addr/syn_weight/syn_vld/syn_rdy in; neuron_addr/neuron_charge/neuron_vld/neuron_rdy out.
module ucaspian_dendrite
    import ucaspian_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear_act,
    output logic                     clear_done,
    input  logic                     next_step,
    output logic                     step_done,
    input  logic [NEURON_ADDR_W-1:0] syn_addr,
    input  logic [WEIGHT_W-1:0]      syn_weight,
    input  logic                     syn_vld,
    output logic                     syn_rdy,
    output logic [NEURON_ADDR_W-1:0] neuron_addr,
    output logic [CHARGE_W-1:0]      neuron_charge,
    output logic                     neuron_vld,
    input  logic                     neuron_rdy
);

    dendrite_state_t state;

    logic [NEURON_ADDR_W-1:0] addr;
    logic [WEIGHT_W-1:0]      weight;
    logic                     step_pending;

    logic                     rd_en;
    logic [NEURON_ADDR_W-1:0] rd_addr;
    logic [CHARGE_W-1:0]      rd_data;
    logic                     wr_en;
    logic [NEURON_ADDR_W-1:0] wr_addr;
    logic [CHARGE_W-1:0]      wr_data;

    logic syn_fire;
    logic last;
    logic drain_go;
    logic rd_nz;

    assign syn_fire = syn_vld && syn_rdy;
    assign last     = (addr == NEURON_ADDR_W'(NUM_NEURONS - 1));
    // A pulse arriving while idle starts the drain without a detour through the flag.
    assign drain_go = (step_pending || next_step) && enable;
    assign rd_nz    = (rd_data != '0);

    dp_ram_16x256 u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // RAM port control; writes are suppressed on the cycle a clear takes over.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = addr;
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = '0;
        unique case (state)
            IDLE: begin
                rd_en   = syn_fire && !clear_act;
                rd_addr = syn_addr;
            end
            ACC_WR: begin
                wr_en   = !clear_act;
                wr_data = sat_add_charge(rd_data, weight);
            end
            DRN_RD:  rd_en = 1'b1;
            DRN_CHK: wr_en = rd_nz && !clear_act;
            CLEAR:   wr_en = clear_act && !clear_done;
            ACC_RD, DRN_OUT, DONE: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            weight        <= '0;
            step_pending  <= 1'b0;
            syn_rdy       <= 1'b0;
            neuron_vld    <= 1'b0;
            neuron_addr   <= '0;
            neuron_charge <= '0;
            step_done     <= 1'b0;
            clear_done    <= 1'b0;
        end else if (clear_act && state != CLEAR) begin
            state        <= CLEAR;
            addr         <= '0;
            step_pending <= 1'b0;
            syn_rdy      <= 1'b0;
            neuron_vld   <= 1'b0;
            step_done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    syn_rdy <= enable;
                    if (syn_fire) begin
                        addr    <= syn_addr;
                        weight  <= syn_weight;
                        syn_rdy <= 1'b0;
                        state   <= ACC_RD;
                    end else if (drain_go) begin
                        addr         <= '0;
                        syn_rdy      <= 1'b0;
                        step_pending <= 1'b1;
                        state        <= DRN_RD;
                    end
                end
                ACC_RD: state <= ACC_WR;
                ACC_WR: begin
                    syn_rdy <= enable;
                    state   <= IDLE;
                end
                DRN_RD: state <= DRN_CHK;
                DRN_CHK: begin
                    if (rd_nz) begin
                        neuron_vld    <= 1'b1;
                        neuron_addr   <= addr;
                        neuron_charge <= rd_data;
                        state         <= DRN_OUT;
                    end else if (last) begin
                        step_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= DRN_RD;
                    end
                end
                DRN_OUT: begin
                    if (neuron_rdy) begin
                        neuron_vld <= 1'b0;
                        if (last) begin
                            step_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= DRN_RD;
                        end
                    end
                end
                DONE: begin
                    step_done    <= 1'b0;
                    step_pending <= 1'b0;
                    syn_rdy      <= enable;
                    state        <= IDLE;
                end
                CLEAR: begin
                    if (!clear_act) begin
                        clear_done <= 1'b0;
                        syn_rdy    <= enable;
                        state      <= IDLE;
                    end else if (!clear_done) begin
                        if (last)
                            clear_done <= 1'b1;
                        else
                            addr <= addr + 1'b1;
                    end
                end
            endcase
            // Placed last so a pulse is never dropped, even on the DONE cycle.
            if (next_step)
                step_pending <= 1'b1;
        end
    end

endmodule
